// File: rtl/qmat_stream_emitter.sv
// qmat_stream_emitter
//
// Emits the luma and/or chroma 8x8 quantisation matrices of a frame header
// into the bitstream writer as a stream of beats. Each beat packs PACK
// elements of ELEM_BITS bits, right-justified in val, with the lowest raster
// index in the most significant field. The beat handshake is
// output_enable/out_ready. Both matrices are snapshotted when start is
// accepted, so the header sequencer may change the inputs straight away.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   start                one-cycle request; honoured only in IDLE
//   load_luma            sampled with start: emit Y_QMAT
//   load_chroma          sampled with start: emit C_QMAT (after Y)
//   Y_QMAT, C_QMAT       8x8 matrices of 32-bit entries, [row][col]; only
//                        the low ELEM_BITS bits of each entry are used
//   out_ready            bit packer accepts the current beat
//   output_enable        beat valid
//   val                  beat payload, right-justified
//   size_of_bit          valid bits in val (PACK*ELEM_BITS while valid)
//   flush_bit            byte-align flush request with this beat
//   busy                 high while beats are being emitted
//   done                 one-cycle pulse at sequence end
module qmat_stream_emitter #(
    parameter int unsigned ELEM_BITS    = 8,
    parameter int unsigned PACK         = 1,
    parameter int unsigned FLUSH_AT_END = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   load_luma,
    input  logic                   load_chroma,
    input  logic [7:0][7:0][31:0]  Y_QMAT,
    input  logic [7:0][7:0][31:0]  C_QMAT,
    input  logic                   out_ready,
    output logic                   output_enable,
    output logic [63:0]            val,
    output logic [63:0]            size_of_bit,
    output logic                   flush_bit,
    output logic                   busy,
    output logic                   done
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (!(PACK == 1 || PACK == 2 || PACK == 4 || PACK == 8)) begin : g_bad_pack
            $error("qmat_stream_emitter: PACK must be 1, 2, 4 or 8");
        end
        if (PACK * ELEM_BITS > 64) begin : g_bad_width
            $error("qmat_stream_emitter: PACK*ELEM_BITS must not exceed 64");
        end
        if (ELEM_BITS < 1 || ELEM_BITS > 32) begin : g_bad_elem
            $error("qmat_stream_emitter: ELEM_BITS must be 1..32");
        end
    endgenerate

    localparam int unsigned BEAT_BITS = PACK * ELEM_BITS;
    localparam int unsigned BEATS     = 64 / PACK;
    localparam logic [5:0]  LAST_BEAT = 6'(BEATS - 1);
    localparam logic [63:0] SOB       = 64'(BEAT_BITS);
    localparam logic        FLUSH_EN  = (FLUSH_AT_END != 0);

    typedef logic [63:0][ELEM_BITS-1:0] mat_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT_Y,
        EMIT_C,
        FINISH
    } state_t;

    state_t      state_q;
    logic [5:0]  idx_q;
    logic [5:0]  idx_d;
    logic        chroma_q;
    logic        oe_q;
    logic [63:0] val_q;
    logic [63:0] sob_q;
    logic        flush_q;
    logic        busy_q;
    logic        done_q;

    mat_t        y_in;
    mat_t        c_in;
    mat_t        y_q;
    mat_t        c_q;

    // The upper entry bits are intentionally ignored.
    logic        unused_inputs;
    assign unused_inputs = ^{Y_QMAT, C_QMAT};

    // ------------------------------------------------------------------
    // Flatten the element fields into raster order
    // ------------------------------------------------------------------
    always_comb begin
        y_in = '0;
        c_in = '0;
        for (int unsigned r = 0; r < 8; r++) begin
            for (int unsigned c = 0; c < 8; c++) begin
                y_in[6'(r * 8 + c)] = Y_QMAT[3'(r)][3'(c)][ELEM_BITS-1:0];
                c_in[6'(r * 8 + c)] = C_QMAT[3'(r)][3'(c)][ELEM_BITS-1:0];
            end
        end
    end

    // Build beat b of matrix m: element b*PACK lands in the top field.
    function automatic logic [63:0] pack_beat(input mat_t m, input logic [5:0] b);
        logic [63:0] r;
        logic [5:0]  e;
        r = '0;
        for (int unsigned p = 0; p < PACK; p++) begin
            e = 6'(32'(b) * PACK + p);
            r[(PACK - 1 - p) * ELEM_BITS +: ELEM_BITS] = m[e];
        end
        return r;
    endfunction

    assign idx_d = idx_q + 6'd1;

    // ------------------------------------------------------------------
    // Snapshot of both matrices, taken when start is accepted
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset && state_q == IDLE && start) begin
            y_q <= y_in;
            c_q <= c_in;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer with registered outputs
    // ------------------------------------------------------------------
    // The first beat is loaded in the same edge that accepts start, so it
    // is built from the live inputs rather than from the snapshot, which
    // is only being written on that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            chroma_q <= 1'b0;
            oe_q     <= 1'b0;
            val_q    <= '0;
            sob_q    <= '0;
            flush_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        chroma_q <= load_chroma;
                        idx_q    <= '0;
                        if (load_luma) begin
                            state_q <= EMIT_Y;
                            oe_q    <= 1'b1;
                            val_q   <= pack_beat(y_in, 6'd0);
                            sob_q   <= SOB;
                            flush_q <= FLUSH_EN && !load_chroma && (LAST_BEAT == 6'd0);
                            busy_q  <= 1'b1;
                        end else if (load_chroma) begin
                            state_q <= EMIT_C;
                            oe_q    <= 1'b1;
                            val_q   <= pack_beat(c_in, 6'd0);
                            sob_q   <= SOB;
                            flush_q <= FLUSH_EN && (LAST_BEAT == 6'd0);
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end
                    end
                end

                EMIT_Y: begin
                    if (out_ready) begin
                        if (idx_q == LAST_BEAT) begin
                            idx_q <= '0;
                            if (chroma_q) begin
                                state_q <= EMIT_C;
                                val_q   <= pack_beat(c_q, 6'd0);
                                flush_q <= FLUSH_EN && (LAST_BEAT == 6'd0);
                            end else begin
                                state_q <= FINISH;
                                oe_q    <= 1'b0;
                                val_q   <= '0;
                                sob_q   <= '0;
                                flush_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            idx_q   <= idx_d;
                            val_q   <= pack_beat(y_q, idx_d);
                            flush_q <= FLUSH_EN && !chroma_q && (idx_d == LAST_BEAT);
                        end
                    end
                end

                EMIT_C: begin
                    if (out_ready) begin
                        if (idx_q == LAST_BEAT) begin
                            state_q <= FINISH;
                            idx_q   <= '0;
                            oe_q    <= 1'b0;
                            val_q   <= '0;
                            sob_q   <= '0;
                            flush_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_d;
                            val_q   <= pack_beat(c_q, idx_d);
                            flush_q <= FLUSH_EN && (idx_d == LAST_BEAT);
                        end
                    end
                end

                FINISH: begin
                    // start is deliberately not looked at here
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    oe_q    <= 1'b0;
                    val_q   <= '0;
                    sob_q   <= '0;
                    flush_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign output_enable = oe_q;
    assign val           = val_q;
    assign size_of_bit   = sob_q;
    assign flush_bit     = flush_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
